// File: rtl/freq_meas_scheduler.sv
// Multi-channel reciprocal frequency counter: one shared event/reference counter pair is
// scanned round-robin over the enabled inputs, with an 8-bit Avalon-MM register slave.
module freq_meas_scheduler #(
    parameter int unsigned NCH            = 4,
    parameter int unsigned GATE_PRESCALE  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 16777216
) (
    input  logic           csi_MCLK_clk,
    input  logic           rsi_MRST_reset_n,
    input  logic [3:0]     avs_ctrl_address,
    input  logic [7:0]     avs_ctrl_writedata,
    input  logic           avs_ctrl_write,
    input  logic           avs_ctrl_read,
    output logic [7:0]     avs_ctrl_readdata,
    input  logic [NCH-1:0] freq_in,
    output logic           busy,
    output logic           irq
);
    localparam int unsigned      CW       = 32;
    localparam int unsigned      MAXCH    = 4;
    localparam logic [MAXCH-1:0] CH_MASK  = MAXCH'((1 << NCH) - 1);
    localparam logic [CW-1:0]    CNT_MAX  = '1;
    localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]    PRESCALE = CW'(GATE_PRESCALE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_GATE   = 3'd3;
    localparam logic [2:0] S_CLOSE  = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             run_q, run_d, start_q, start_d, irq_en_q, irq_en_d;
    logic [3:0]       mask_q, mask_d, pend_q, pend_d;
    logic [15:0]      gate_q, gate_d;
    logic [3:0]       valid_q, valid_d, tmo_q, tmo_d;
    logic [1:0]       chsel_q, chsel_d, ch_q, ch_d, last_q, last_d;
    logic [63:0]      shadow_q, shadow_d;
    logic [CW-1:0]    res_ev_q [MAXCH];
    logic [CW-1:0]    res_ev_d [MAXCH];
    logic [CW-1:0]    res_ref_q [MAXCH];
    logic [CW-1:0]    res_ref_d [MAXCH];
    logic [CW-1:0]    ev_q, ev_d, ref_q, ref_d, timer_q, timer_d, wait_q, wait_d;
    logic             to_flag_q, to_flag_d, prev_q, prev_d;
    logic [NCH-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             busy_q, busy_d, irq_q, irq_d;

    logic [MAXCH-1:0] sync_pad, sel_set;
    logic             edge_det, have_next;
    logic [1:0]       next_ch;
    logic [CW-1:0]    gate_len;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Synchroniser, edge detect on the selected channel and round-robin pick.
    always_comb begin
        sync1_d  = freq_in;
        sync2_d  = sync1_q;
        sync_pad = MAXCH'(sync2_q);
        edge_det = sync_pad[ch_q] & ~prev_q;
        gate_len = ((gate_q == 16'd0) ? CW'(1) : CW'(gate_q)) * PRESCALE;
        sel_set  = (run_q ? mask_q : pend_q) & CH_MASK;
        next_ch  = last_q;
        have_next = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!have_next && sel_set[2'(int'(last_q) + i)]) begin
                next_ch   = 2'(int'(last_q) + i);
                have_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        start_d   = 1'b0;
        irq_en_d  = irq_en_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        gate_d    = gate_q;
        valid_d   = valid_q;
        tmo_d     = tmo_q;
        chsel_d   = chsel_q;
        ch_d      = ch_q;
        last_d    = last_q;
        shadow_d  = shadow_q;
        res_ev_d  = res_ev_q;
        res_ref_d = res_ref_q;
        ev_d      = ev_q;
        ref_d     = ref_q;
        timer_d   = timer_q;
        wait_d    = wait_q;
        to_flag_d = to_flag_q;
        prev_d    = sync_pad[ch_q];
        rdata_d   = 8'h00;

        if (avs_ctrl_write) begin
            case (avs_ctrl_address)
                4'd0: begin
                    run_d    = avs_ctrl_writedata[0];
                    start_d  = avs_ctrl_writedata[1];
                    irq_en_d = avs_ctrl_writedata[2];
                    mask_d   = avs_ctrl_writedata[7:4];
                end
                4'd1: gate_d[7:0]  = avs_ctrl_writedata;
                4'd2: gate_d[15:8] = avs_ctrl_writedata;
                4'd3: begin
                    valid_d = valid_q & ~avs_ctrl_writedata[3:0];
                    tmo_d   = tmo_q & ~avs_ctrl_writedata[7:4];
                end
                4'd4: chsel_d = avs_ctrl_writedata[1:0];
                default: ;
            endcase
        end

        // Address 8 latches the whole result so later byte reads stay coherent.
        if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                4'd0:  rdata_d = {mask_q, 1'b0, irq_en_q, 1'b0, run_q};
                4'd1:  rdata_d = gate_q[7:0];
                4'd2:  rdata_d = gate_q[15:8];
                4'd3:  rdata_d = {tmo_q, valid_q};
                4'd4:  rdata_d = {6'b0, chsel_q};
                4'd8: begin
                    shadow_d = {res_ref_q[chsel_q], res_ev_q[chsel_q]};
                    rdata_d  = res_ev_q[chsel_q][7:0];
                end
                4'd9:  rdata_d = shadow_q[15:8];
                4'd10: rdata_d = shadow_q[23:16];
                4'd11: rdata_d = shadow_q[31:24];
                4'd12: rdata_d = shadow_q[39:32];
                4'd13: rdata_d = shadow_q[47:40];
                4'd14: rdata_d = shadow_q[55:48];
                4'd15: rdata_d = shadow_q[63:56];
                default: rdata_d = 8'h00;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if ((start_q || run_q) && ((mask_q & CH_MASK) != 4'd0)) begin
                    pend_d  = run_q ? 4'd0 : (mask_q & CH_MASK);
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (have_next) begin
                    ch_d            = next_ch;
                    last_d          = next_ch;
                    pend_d[next_ch] = 1'b0;
                    ev_d            = '0;
                    ref_d           = '0;
                    timer_d         = '0;
                    wait_d          = '0;
                    to_flag_d       = 1'b0;
                    prev_d          = sync_pad[next_ch];
                    state_d         = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (edge_det) begin
                    ev_d    = '0;
                    ref_d   = '0;
                    timer_d = gate_len;
                    state_d = S_GATE;
                end else if (wait_q == TO_LAST) begin
                    to_flag_d = 1'b1;
                    state_d   = S_STORE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_GATE: begin
                ref_d   = sat_inc(ref_q);
                ev_d    = edge_det ? sat_inc(ev_q) : ev_q;
                timer_d = timer_q - CW'(1);
                if (timer_d == '0) begin
                    wait_d  = '0;
                    state_d = edge_det ? S_STORE : S_CLOSE;
                end
            end
            S_CLOSE: begin
                ref_d = sat_inc(ref_q);
                ev_d  = edge_det ? sat_inc(ev_q) : ev_q;
                if (edge_det) begin
                    state_d = S_STORE;
                end else if (wait_q == TO_LAST) begin
                    to_flag_d = 1'b1;
                    state_d   = S_STORE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_STORE: begin
                // Flag sets land after the W1C above so a simultaneous clear loses.
                res_ev_d[ch_q]  = to_flag_q ? '0 : ev_q;
                res_ref_d[ch_q] = to_flag_q ? '0 : ref_q;
                valid_d[ch_q]   = 1'b1;
                if (to_flag_q) tmo_d[ch_q] = 1'b1;
                if ((run_q && ((mask_q & CH_MASK) != 4'd0)) || (pend_q != 4'd0))
                    state_d = S_SELECT;
                else
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        irq_d  = |(valid_d & {4{irq_en_d}});
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            start_q   <= 1'b0;
            irq_en_q  <= 1'b0;
            mask_q    <= '0;
            pend_q    <= '0;
            gate_q    <= '0;
            valid_q   <= '0;
            tmo_q     <= '0;
            chsel_q   <= '0;
            ch_q      <= '0;
            last_q    <= 2'(MAXCH - 1);
            shadow_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                res_ev_q[i]  <= '0;
                res_ref_q[i] <= '0;
            end
            ev_q      <= '0;
            ref_q     <= '0;
            timer_q   <= '0;
            wait_q    <= '0;
            to_flag_q <= 1'b0;
            prev_q    <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            start_q   <= start_d;
            irq_en_q  <= irq_en_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            gate_q    <= gate_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
            chsel_q   <= chsel_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            shadow_q  <= shadow_d;
            res_ev_q  <= res_ev_d;
            res_ref_q <= res_ref_d;
            ev_q      <= ev_d;
            ref_q     <= ref_d;
            timer_q   <= timer_d;
            wait_q    <= wait_d;
            to_flag_q <= to_flag_d;
            prev_q    <= prev_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
        end
    end

    assign avs_ctrl_readdata = rdata_q;
    assign busy              = busy_q;
    assign irq               = irq_q;
endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Directed bench for freq_meas_scheduler; expected results come from a reciprocal-count
// model (ev = ceil(gate/period), ref = ev*period) and a round-robin service model.
`timescale 1ns/1ps
module tb_freq_meas_scheduler;
    localparam int PRE = 10;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       wr_en, rd_en;
    logic [7:0] rdata;
    logic [3:0] freq;
    logic       busy, irq;

    int vectors = 0;
    int miscompares = 0;
    int per [4];
    int ph [4];
    int m_last;

    bit         do_chk = 1'b0;
    logic [7:0] exp_rd;
    string      exp_nm;
    bit         pend_v = 1'b0;
    logic [7:0] pend_exp;
    string      pend_nm;

    always #5 clk = ~clk;

    freq_meas_scheduler #(.NCH(4), .GATE_PRESCALE(PRE), .TIMEOUT_CYCLES(TMO)) dut (
        .csi_MCLK_clk      (clk),
        .rsi_MRST_reset_n  (rst_n),
        .avs_ctrl_address  (addr),
        .avs_ctrl_writedata(wdata),
        .avs_ctrl_write    (wr_en),
        .avs_ctrl_read     (rd_en),
        .avs_ctrl_readdata (rdata),
        .freq_in           (freq),
        .busy              (busy),
        .irq               (irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int m_ev(input int g, input int p);
        int t = ((g == 0) ? 1 : g) * PRE;
        return (t + p - 1) / p;
    endfunction

    function automatic int m_next(input int last, input logic [3:0] m);
        for (int i = 1; i <= 4; i++)
            if (m[(last + i) % 4]) return (last + i) % 4;
        return last;
    endfunction

    // Periodic inputs: a rising edge every per[c] clocks, held low when per[c]==0.
    initial begin
        freq = 4'h0;
        forever begin
            @(posedge clk);
            #2;
            for (int c = 0; c < 4; c++) begin
                if (per[c] == 0) begin
                    ph[c]   = 0;
                    freq[c] = 1'b0;
                end else begin
                    ph[c]   = (ph[c] + 1) % per[c];
                    freq[c] = (ph[c] < per[c] / 2);
                end
            end
        end
    end

    // Read-data checker: a checked read issued in one cycle is compared the next.
    always @(negedge clk) begin
        if (pend_v) chk(pend_nm, 32'(rdata), 32'(pend_exp));
        pend_v   = rd_en && do_chk;
        pend_exp = exp_rd;
        pend_nm  = exp_nm;
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd_bus(input logic [3:0] a, input bit c, input logic [7:0] e,
                          input string nm, output logic [7:0] d);
        addr = a; rd_en = 1'b1; do_chk = c; exp_rd = e; exp_nm = nm;
        @(posedge clk); #1;
        rd_en = 1'b0; do_chk = 1'b0;
        d = rdata;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
        logic [7:0] d;
        rd_bus(a, 1'b1, e, nm, d);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        repeat (3) @(posedge clk);
        #1;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input logic [3:0] m, input string nm, input int budget);
        logic [7:0] s = 8'h00;
        int n = 0;
        while (((s[3:0] & m) == 4'd0) && n < budget) begin
            rd_bus(4'd3, 1'b0, 8'h00, "", s);
            n++;
        end
        chk(nm, 32'((s[3:0] & m) != 4'd0), 32'd1);
    endtask

    task automatic check_result(input int ch, input int g, input string nm);
        int ev = m_ev(g, per[ch]);
        int rf = ev * per[ch];
        wr(4'd4, 8'(ch));
        rd(4'd8,  8'(ev),      $sformatf("%s_ev0", nm));
        rd(4'd12, 8'(rf),      $sformatf("%s_ref0", nm));
        rd(4'd13, 8'(rf >> 8), $sformatf("%s_ref1", nm));
    endtask

    initial begin
        automatic int ord[$];
        automatic int e;
        automatic int chs[3] = '{0, 1, 3};
        logic [7:0] s;
        int n;

        addr = 4'h0; wdata = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
        for (int c = 0; c < 4; c++) per[c] = 0;
        m_last = 3;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #5;
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_irq",   32'(irq),   32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(4'd0, 8'h00, "reset_ctrl");
        rd(4'd1, 8'h00, "reset_gate_lo");
        rd(4'd3, 8'h00, "reset_status");

        // Single shot on channel 0, G=10, period 10.
        per[0] = 10;
        wr(4'd1, 8'd10);
        wr(4'd2, 8'd0);
        wr(4'd0, 8'h16);
        repeat (3) @(posedge clk);
        #1 chk("t1_busy_high", 32'(busy), 32'd1);
        wait_idle("t1_busy_falls", 2000);
        m_last = m_next(m_last, 4'b0001);
        chk("t1_irq", 32'(irq), 32'd1);
        rd(4'd3, 8'h01, "t1_status");
        wr(4'd4, 8'd0);
        rd(4'd8,  8'd10, "t1_ev0");
        rd(4'd9,  8'd0,  "t1_ev1");
        rd(4'd12, 8'd100, "t1_ref0");
        rd(4'd13, 8'd0,  "t1_ref1");
        rd(4'd0, 8'h14, "t1_ctrl_start_reads0");
        wr(4'd3, 8'h01);
        #1 chk("t1_irq_cleared", 32'(irq), 32'd0);

        // Continuous scan over mask 1011 with distinct periods.
        per[0] = 8; per[1] = 12; per[2] = 5; per[3] = 20;
        wr(4'd3, 8'hFF);
        wr(4'd0, 8'hB1);
        n = 0;
        while (ord.size() < 6 && n < 5000) begin
            rd_bus(4'd3, 1'b0, 8'h00, "", s);
            for (int c = 0; c < 4; c++) begin
                if (s[c]) begin
                    ord.push_back(c);
                    wr(4'd3, 8'(1 << c));
                end
            end
            n++;
        end
        e = m_last;
        for (int k = 0; k < 6; k++) begin
            e = m_next(e, 4'b1011);
            chk($sformatf("scan_order_%0d", k), (k < ord.size()) ? 32'(ord[k]) : 32'hFF, 32'(e));
        end
        wr(4'd0, 8'hB0);
        wait_idle("scan_stop_idle", 2000);
        foreach (chs[i]) check_result(chs[i], 10, $sformatf("scan_ch%0d", chs[i]));

        // Channel 0 held low times out; channel 2 still gets measured.
        per[0] = 0; per[2] = 10;
        wr(4'd3, 8'hFF);
        repeat (5) @(posedge clk);
        #1;
        wr(4'd0, 8'h52);
        wait_idle("tmo_idle", 3000);
        rd(4'd3, 8'h15, "tmo_status");
        wr(4'd4, 8'd0);
        rd(4'd8,  8'd0, "tmo_ch0_ev0");
        rd(4'd12, 8'd0, "tmo_ch0_ref0");
        check_result(2, 10, "tmo_ch2");

        // Shadow coherency: snapshot, then newer stores must not leak into bytes 9..15.
        per[0] = 10;
        wr(4'd3, 8'hFF);
        wr(4'd4, 8'd0);
        wr(4'd1, 8'd30);
        wr(4'd0, 8'h11);
        wait_valid(4'b0001, "shd_first", 3000);
        rd(4'd8, 8'(m_ev(30, 10)), "shd_snap_ev0");
        wr(4'd1, 8'd60);
        wr(4'd3, 8'h01);
        wait_valid(4'b0001, "shd_second", 3000);
        wr(4'd3, 8'h01);
        wait_valid(4'b0001, "shd_third", 3000);
        rd(4'd9,  8'd0, "shd_old_ev1");
        rd(4'd10, 8'd0, "shd_old_ev2");
        rd(4'd11, 8'd0, "shd_old_ev3");
        rd(4'd12, 8'(m_ev(30, 10) * 10), "shd_old_ref0");
        rd(4'd13, 8'((m_ev(30, 10) * 10) >> 8), "shd_old_ref1");
        rd(4'd8,  8'(m_ev(60, 10)), "shd_new_ev0");
        rd(4'd12, 8'(m_ev(60, 10) * 10), "shd_new_ref0");
        rd(4'd13, 8'((m_ev(60, 10) * 10) >> 8), "shd_new_ref1");
        wr(4'd0, 8'h10);
        wait_idle("shd_stop_idle", 3000);

        // Reset in the middle of a long gate aborts without a store.
        wr(4'd1, 8'hE8);
        wr(4'd2, 8'h03);
        wr(4'd0, 8'h16);
        repeat (200) @(posedge clk);
        #1;
        chk("rst_busy_before", 32'(busy), 32'd1);
        chk("rst_irq_before",  32'(irq),  32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy_now",  32'(busy),  32'd0);
        chk("rst_irq_now",   32'(irq),   32'd0);
        chk("rst_rdata_now", 32'(rdata), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(4'd0,  8'h00, "rst_ctrl");
        rd(4'd2,  8'h00, "rst_gate_hi");
        rd(4'd3,  8'h00, "rst_status");
        rd(4'd12, 8'h00, "rst_shadow_ref0");
        rd(4'd8,  8'h00, "rst_result_ev0");
        repeat (20) @(posedge clk);
        #1 chk("rst_stays_idle", 32'(busy), 32'd0);

        // Zero mask never leaves IDLE.
        wr(4'd0, 8'h03);
        repeat (5) @(posedge clk);
        #1 chk("zero_mask_busy", 32'(busy), 32'd0);
        rd(4'd3, 8'h00, "zero_mask_status");
        wr(4'd0, 8'h00);

        // G=0 behaves as G=1: a gate of PRE clocks.
        per[0] = 10;
        wr(4'd0, 8'h12);
        wait_idle("g0_idle", 2000);
        rd(4'd3, 8'h01, "g0_status");
        wr(4'd4, 8'd0);
        rd(4'd8,  8'd1,  "g0_ev0");
        rd(4'd12, 8'd10, "g0_ref0");
        chk("g0_irq_disabled", 32'(irq), 32'd0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
- Multi-channel reciprocal-counting controller. It time-shares one event/reference counter pair across NCH frequency inputs.
- For each enabled channel in round-robin order it selects the input and arms on an input edge. It runs a programmable gate, closes on the first input edge after the gate expires, and snapshots the counts into per-channel result registers.
- It is an Avalon-MM slave (8-bit data) under Qsys, so software gets gate-synchronous period counts for all channels without babysitting each one.

Parameters:
- NCH, 4, number of frequency inputs (1..4).
- GATE_PRESCALE, 1000, clocks per gate LSB.
- TIMEOUT_CYCLES, 16777216, maximum clocks spent waiting for an input edge in ARM or CLOSE.

Ports:
- csi_MCLK_clk  in  1  sole clock.
- rsi_MRST_reset_n  in  1  asynchronous, active-low reset.
- avs_ctrl_address  in  4  register address.
- avs_ctrl_writedata  in  8  write data.
- avs_ctrl_write  in  1  write strobe.
- avs_ctrl_read  in  1  read strobe.
- avs_ctrl_readdata  out  8  registered read data.
- freq_in  in  NCH  asynchronous frequency inputs.
- busy  out  1  high outside IDLE.
- irq  out  1  level; (valid & irq_en) != 0.

Behaviour:
- Register map:
  - 0 CTRL: [0] run, [1] start (self-clearing, reads 0), [2] irq_en, [7:4] channel enable mask.
  - 1/2 GATE_LO/GATE_HI: 16-bit gate G. Gate length = G*GATE_PRESCALE clocks; G=0 is treated as 1.
  - 3 STATUS: [3:0] valid, [7:4] timeout. Write-1-to-clear.
  - 4 CH_SEL: [1:0] readback channel.
  - 8..11: event count (bytes 0..3 of the selected channel).
  - 12..15: reference count (bytes 0..3 of the selected channel).
- Read latency: 1 clock. Unmapped addresses read 0.
- Reading address 8 copies the selected channel's 64-bit result into a shadow register the same cycle. Addresses 8..15 return shadow bytes, so a multi-byte read is coherent.
- freq_in: 2-FF synchroniser plus rising-edge detect on the selected channel only. Edge detect history is reset on every channel switch.
- FSM states:
  - IDLE: on start=1 or run=1 with a nonzero mask, go to SELECT. A zero mask keeps the FSM in IDLE with no flags set.
  - SELECT (1 clock): choose the next enabled channel after the last-serviced one (wraps; channel 0 first after reset). Clear the counters and the edge history. Go to ARM.
  - ARM: wait for a rising edge.
    - On the edge (open cycle): ev=0, ref=0, gate timer=G*GATE_PRESCALE. Go to GATE.
    - After TIMEOUT_CYCLES with no edge: go to STORE with the timeout flag set.
  - GATE: each subsequent clock, ref+=1 and timer-=1; each edge, ev+=1. When timer==0, go to CLOSE in the same cycle.
  - CLOSE: keep counting. The first rising edge seen in a cycle where timer==0 (includes the expiry cycle) closes the measurement; that edge is counted. No edge within TIMEOUT_CYCLES gives a timeout.
  - STORE (1 clock):
    - Normal close: write ev/ref to the channel result and set valid[ch].
    - Timeout: write ev=0, ref=0 and set timeout[ch] and valid[ch].
    - Then go to SELECT if run=1 or single-shot channels remain, else IDLE.
- Single-shot (start with run=0) measures each channel enabled at start once, then returns to IDLE.
- Counters are 32-bit and saturate at 0xFFFFFFFF; they never wrap.
- Clearing run mid-measurement finishes the current channel, then goes to IDLE.
- Changes to mask or gate are sampled at SELECT/open, so they do not affect a measurement already in progress.
- A STATUS W1C in the same cycle as a STORE set of the same bit leaves the bit set (set wins).
- Reset values: all registers, results, shadow and flags are 0; readdata=0; busy=0; irq=0; FSM in IDLE. Asserting reset mid-measurement aborts immediately; no STORE happens.
- Result meaning: f = ev*Fclk/ref.

Test Plan:
- GATE_PRESCALE=10, G=10, mask=0001, start; freq_in[0] period 10 clk, aligned. Required: ev=10, ref=100, valid=0001, busy falls, irq=1 if irq_en.
- Mask=1011, run=1, distinct periods 8/12/20 clk. Required: service order 0,1,3,0,…, never channel 2; each result has ref = ev*period.
- Input held low, TIMEOUT_CYCLES=64. Required: timeout[ch]=1, valid[ch]=1, result 0/0; scan continues to the next channel.
- Read address 8, then inject a new STORE into the same channel before reading address 11. Required: bytes 9..11 come from the old snapshot.
- Assert reset during GATE. Required: all outputs 0 and IDLE next cycle; no valid bit; G=0 yields a gate of GATE_PRESCALE clocks.
